// File: rtl/axi_trng_regs.sv
// AXI4-Lite register front-end for a true random number generator: control,
// status, a pop-on-read data port backed by an entropy FIFO, and scratch registers.
module axi_trng_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_REGS           = 8,
    parameter int FIFO_DEPTH         = 16
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     rnd_data,
    input  logic                              rnd_valid,
    output logic                              rnd_ready,
    output logic                              irq
);

    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int AW       = C_S_AXI_ADDR_WIDTH;
    localparam int STRB_W   = DW / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = $clog2(NUM_REGS);
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = PTR_W + 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [IDX_W-1:0] IDX_CTRL   = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_STATUS = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_DATA   = IDX_W'(2);

    typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} r_state_t;

    function automatic logic addr_in_range(input logic [AW-1:0] addr);
        return (addr >> (ADDR_LSB + IDX_W)) == '0;
    endfunction

    function automatic logic [DW-1:0] apply_strobe(input logic [DW-1:0] old_val,
                                                   input logic [DW-1:0] new_val,
                                                   input logic [STRB_W-1:0] strb);
        logic [DW-1:0] res;
        res = old_val;
        for (int b = 0; b < STRB_W; b++)
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        return res;
    endfunction

    w_state_t w_state, w_state_n;
    r_state_t r_state, r_state_n;
    logic     w_accept, r_accept;

    logic                 en, irq_en, underflow, drop;
    logic [7:0]           thresh;
    logic [DW-1:0]        scratch [NUM_REGS];
    logic [DW-1:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [1:0]           bresp_q, rresp_q;
    logic [DW-1:0]        rdata_q;

    logic                 empty, full, push, pop, clr, wr_en;
    logic                 underflow_set, drop_set, rd_data_sel;
    logic                 w_addr_ok, r_addr_ok;
    logic [IDX_W-1:0]     w_idx, r_idx;
    logic [DW-1:0]        rd_word;
    logic                 rd_err;

    logic unused_ok;
    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot,
                         s00_axi_awaddr[ADDR_LSB-1:0], s00_axi_araddr[ADDR_LSB-1:0]};

    // ---------------- write channel FSM ----------------
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) w_state <= W_IDLE;
        else                w_state <= w_state_n;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_n      = w_state;
        w_accept       = 1'b0;
        s00_axi_bvalid = 1'b0;
        unique case (w_state)
            W_IDLE: if (s00_axi_awvalid && s00_axi_wvalid) w_state_n = W_ACK;
            W_ACK: begin
                w_accept  = 1'b1;
                w_state_n = W_RESP;
            end
            W_RESP: begin
                s00_axi_bvalid = 1'b1;
                if (s00_axi_bready) w_state_n = W_IDLE;
            end
            default: w_state_n = W_IDLE;
        endcase
    end

    assign s00_axi_awready = w_accept;
    assign s00_axi_wready  = w_accept;
    assign s00_axi_bresp   = bresp_q;

    // ---------------- read channel FSM ----------------
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) r_state <= R_IDLE;
        else                r_state <= r_state_n;
    end

    always_comb begin
        r_state_n      = r_state;
        r_accept       = 1'b0;
        s00_axi_rvalid = 1'b0;
        unique case (r_state)
            R_IDLE: if (s00_axi_arvalid) r_state_n = R_ACK;
            R_ACK: begin
                r_accept  = 1'b1;
                r_state_n = R_DATA;
            end
            R_DATA: begin
                s00_axi_rvalid = 1'b1;
                if (s00_axi_rready) r_state_n = R_IDLE;
            end
            default: r_state_n = R_IDLE;
        endcase
    end

    assign s00_axi_arready = r_accept;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = rresp_q;

    // ---------------- decode ----------------
    assign w_addr_ok = addr_in_range(s00_axi_awaddr);
    assign r_addr_ok = addr_in_range(s00_axi_araddr);
    assign w_idx     = s00_axi_awaddr[ADDR_LSB +: IDX_W];
    assign r_idx     = s00_axi_araddr[ADDR_LSB +: IDX_W];

    assign empty         = (count == '0);
    assign full          = (count == CNT_W'(FIFO_DEPTH));
    assign rnd_ready     = en & ~full;
    assign push          = rnd_valid & rnd_ready;
    assign drop_set      = rnd_valid & en & full;
    assign wr_en         = w_accept & w_addr_ok;
    assign clr           = wr_en & (w_idx == IDX_CTRL) & s00_axi_wstrb[0] & s00_axi_wdata[1];
    assign rd_data_sel   = r_accept & r_addr_ok & (r_idx == IDX_DATA);
    assign pop           = rd_data_sel & ~empty;
    assign underflow_set = rd_data_sel & empty;

    always_comb begin
        rd_word = '0;
        rd_err  = 1'b0;
        if (!r_addr_ok) begin
            rd_err = 1'b1;
        end else begin
            case (r_idx)
                IDX_CTRL: begin
                    rd_word[0]    = en;
                    rd_word[2]    = irq_en;
                    rd_word[15:8] = thresh;
                end
                IDX_STATUS: begin
                    rd_word[0]    = empty;
                    rd_word[1]    = full;
                    rd_word[2]    = underflow;
                    rd_word[3]    = drop;
                    rd_word[15:8] = 8'(count);
                end
                IDX_DATA: begin
                    if (empty) rd_err  = 1'b1;
                    else       rd_word = fifo_mem[rd_ptr];
                end
                default: rd_word = scratch[r_idx];
            endcase
        end
    end

    // ---------------- response registers ----------------
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            bresp_q <= RESP_OKAY;
            rresp_q <= RESP_OKAY;
            rdata_q <= '0;
        end else begin
            if (w_accept) bresp_q <= w_addr_ok ? RESP_OKAY : RESP_SLVERR;
            if (r_accept) begin
                rresp_q <= rd_err ? RESP_SLVERR : RESP_OKAY;
                rdata_q <= rd_word;
            end
        end
    end

    // ---------------- control, status and scratch ----------------
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            en        <= 1'b0;
            irq_en    <= 1'b0;
            thresh    <= '0;
            underflow <= 1'b0;
            drop      <= 1'b0;
            irq       <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) scratch[i] <= '0;
        end else begin
            if (wr_en) begin
                case (w_idx)
                    IDX_CTRL: begin
                        if (s00_axi_wstrb[0]) begin
                            en     <= s00_axi_wdata[0];
                            irq_en <= s00_axi_wdata[2];
                        end
                        if (s00_axi_wstrb[1]) thresh <= s00_axi_wdata[15:8];
                    end
                    IDX_STATUS: begin
                        if (s00_axi_wstrb[0] && s00_axi_wdata[2]) underflow <= 1'b0;
                        if (s00_axi_wstrb[0] && s00_axi_wdata[3]) drop      <= 1'b0;
                    end
                    IDX_DATA: ;
                    default: scratch[w_idx] <= apply_strobe(scratch[w_idx], s00_axi_wdata,
                                                            s00_axi_wstrb);
                endcase
            end
            // A fresh error event outranks a same-cycle W1C.
            if (underflow_set) underflow <= 1'b1;
            if (drop_set)      drop      <= 1'b1;
            irq <= irq_en & (8'(count) >= thresh) & (thresh != '0);
        end
    end

    // ---------------- entropy FIFO ----------------
    // NOTE: FIFO storage carries no reset; the pointers and count alone define validity.
    always_ff @(posedge s00_axi_aclk) begin
        if (push) fifo_mem[wr_ptr] <= rnd_data;
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: tb/tb_axi_trng_regs.sv
// Self-checking bench for axi_trng_regs: directed and randomized traffic compared
// against a queue-based behavioural model of the register map and entropy FIFO.
module tb_axi_trng_regs;

    localparam int DEPTH = 16;
    localparam int BOUND = 50;

    logic        clk = 1'b0;
    logic        areset;
    logic [5:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata, rnd_data;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        rnd_valid, rnd_ready, irq;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    bit          m_en, m_irq_en, m_und, m_drop;
    logic [7:0]  m_thresh;
    logic [31:0] m_scr [8];
    logic [31:0] mq [$];

    axi_trng_regs dut (
        .s00_axi_aclk(clk), .s00_axi_areset(areset),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
        .s00_axi_awready(awready),
        .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid),
        .s00_axi_wready(wready),
        .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
        .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid),
        .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
        .s00_axi_rready(rready),
        .rnd_data(rnd_data), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- model ----------------
    task automatic m_reset();
        m_en = 0; m_irq_en = 0; m_und = 0; m_drop = 0; m_thresh = 0;
        for (int i = 0; i < 8; i++) m_scr[i] = 0;
        mq.delete();
    endtask

    function automatic bit m_irq();
        return m_irq_en && (m_thresh != 0) && (mq.size() >= int'(m_thresh));
    endfunction

    task automatic m_write(input logic [5:0] addr, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
        int idx;
        idx = int'(addr) / 4 % 8;
        if (addr >= 6'd32) begin
            resp = 2'b10;
            return;
        end
        resp = 2'b00;
        case (idx)
            0: begin
                if (s[0]) begin
                    m_en = d[0];
                    m_irq_en = d[2];
                    if (d[1]) mq.delete();
                end
                if (s[1]) m_thresh = d[15:8];
            end
            1: if (s[0]) begin
                if (d[2]) m_und = 0;
                if (d[3]) m_drop = 0;
            end
            2: ;
            default: for (int b = 0; b < 4; b++) if (s[b]) m_scr[idx][8*b +: 8] = d[8*b +: 8];
        endcase
    endtask

    task automatic m_read(input logic [5:0] addr, output logic [31:0] d, output logic [1:0] resp);
        int idx;
        idx  = int'(addr) / 4 % 8;
        d    = 0;
        resp = 2'b00;
        if (addr >= 6'd32) begin
            resp = 2'b10;
            return;
        end
        case (idx)
            0: d = {16'h0, m_thresh, 5'h0, m_irq_en, 1'b0, m_en};
            1: d = {16'h0, 8'(mq.size()), 4'h0, m_drop, m_und, mq.size() == DEPTH, mq.size() == 0};
            2: if (mq.size() == 0) begin
                resp = 2'b10;
                m_und = 1;
            end else begin
                d = mq.pop_front();
            end
            default: d = m_scr[idx];
        endcase
    endtask

    // ---------------- bus drivers ----------------
    task automatic axi_write(input logic [5:0] addr, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        int n;
        n = 0;
        awaddr = addr; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
        while (!awready && n < BOUND) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0; bready = 1;
        while (!bvalid && n < BOUND) begin @(posedge clk); #1; n++; end
        if (n >= BOUND) check("wr_timeout", 64'(n), 64'(BOUND - 1));
        resp = bresp;
        @(posedge clk); #1;
        bready = 0;
    endtask

    task automatic axi_read(input logic [5:0] addr, output logic [31:0] d, output logic [1:0] resp,
                            output int lat);
        int n;
        n = 0;
        araddr = addr; arvalid = 1;
        while (!arready && n < BOUND) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1; n++;
        arvalid = 0; rready = 1;
        while (!rvalid && n < BOUND) begin @(posedge clk); #1; n++; end
        lat = n;
        d = rdata;
        resp = rresp;
        @(posedge clk); #1;
        rready = 0;
    endtask

    task automatic wr(input logic [5:0] addr, input logic [31:0] d, input logic [3:0] s,
                      input string tag);
        logic [1:0] exp_r, got_r;
        m_write(addr, d, s, exp_r);
        axi_write(addr, d, s, got_r);
        check({tag, "_bresp"}, 64'(got_r), 64'(exp_r));
    endtask

    task automatic rd(input logic [5:0] addr, input string tag);
        logic [31:0] exp_d, got_d;
        logic [1:0]  exp_r, got_r;
        int          lat;
        m_read(addr, exp_d, exp_r);
        axi_read(addr, got_d, got_r, lat);
        check({tag, "_rdata"}, 64'(got_d), 64'(exp_d));
        check({tag, "_rresp"}, 64'(got_r), 64'(exp_r));
        check({tag, "_latency"}, 64'(lat), 64'd2);
    endtask

    // Drives rnd_valid for a number of cycles; the model decides acceptance from EN and fill level.
    task automatic push_cycles(input int cycles, input logic [31:0] word, input bit use_rand);
        for (int c = 0; c < cycles; c++) begin
            logic [31:0] w;
            bit          exp_rdy, irq_prev;
            w = use_rand ? $urandom : word;
            rnd_data = w;
            rnd_valid = 1;
            exp_rdy = m_en && (mq.size() < DEPTH);
            check("rnd_ready", 64'(rnd_ready), 64'(exp_rdy));
            irq_prev = m_irq();
            @(posedge clk); #1;
            if (exp_rdy) mq.push_back(w);
            else if (m_en) m_drop = 1;
            check("irq_lag", 64'(irq), 64'(irq_prev));
        end
        rnd_valid = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] ed, got_d;
        logic [1:0]  er, ew, got_r, got_b;
        int          lat, n;

        areset = 1; awaddr = 0; araddr = 0; awprot = 0; arprot = 0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        wdata = 0; wstrb = 0; rnd_data = 0; rnd_valid = 0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'({awready, wready, arready}), 64'd0);
        check("rst_valid", 64'({bvalid, rvalid}), 64'd0);
        check("rst_resp", 64'({bresp, rresp}), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        check("rst_irq_rdy", 64'({irq, rnd_ready}), 64'd0);
        areset = 0;

        rd(6'h00, "rst_ctrl");
        rd(6'h04, "rst_status");
        rd(6'h0C, "rst_scr3");

        // scratch registers
        for (int i = 3; i < 8; i++) wr(6'(i * 4), 32'(8'h11 * (i - 2)), 4'hF, "scr_w");
        for (int i = 3; i < 8; i++) rd(6'(i * 4), "scr_r");
        wr(6'h0C, 32'hAABBCCDD, 4'h3, "scr_strb_w");
        rd(6'h0C, "scr_strb_r");
        check("scr_strb_const", 64'(m_scr[3]), 64'h0000CCDD);
        for (int k = 0; k < 8; k++) begin
            wr(6'($urandom_range(3, 7) * 4), $urandom, 4'($urandom_range(0, 15)), "scr_rand_w");
            rd(6'($urandom_range(3, 7) * 4), "scr_rand_r");
        end

        // basic FIFO flow and underflow
        wr(6'h00, 32'h1, 4'h1, "en");
        push_cycles(1, 32'hA5A5A5A5, 0);
        push_cycles(1, 32'h5A5A5A5A, 0);
        rd(6'h04, "cnt2_status");
        rd(6'h08, "pop_a5");
        rd(6'h08, "pop_5a");
        rd(6'h08, "pop_empty");
        rd(6'h04, "und_status");
        wr(6'h04, 32'h4, 4'h2, "w1c_nostrb");
        rd(6'h04, "und_kept");
        wr(6'h04, 32'h4, 4'h1, "w1c");
        rd(6'h04, "und_cleared");

        // randomized push/pop traffic
        for (int k = 0; k < 25; k++) begin
            case ($urandom_range(0, 2))
                0: push_cycles($urandom_range(1, 4), 32'h0, 1);
                1: rd(6'h08, "rand_data");
                default: rd(6'h04, "rand_status");
            endcase
        end

        // fill to full, drop, clear
        wr(6'h00, 32'h3, 4'h1, "clr0");
        wr(6'h04, 32'hC, 4'h1, "sticky_clr");
        push_cycles(20, 32'h0, 1);
        rd(6'h04, "full_status");
        check("full_rdy", 64'(rnd_ready), 64'd0);
        check("full_cnt", 64'(mq.size()), 64'(DEPTH));
        wr(6'h00, 32'h3, 4'h1, "clr1");
        rd(6'h04, "clr_status");
        rd(6'h00, "clr_reads0");

        // threshold interrupt
        wr(6'h04, 32'h8, 4'h1, "drop_clr");
        wr(6'h00, 32'h0405, 4'h3, "irq_cfg");
        push_cycles(4, 32'h0, 1);
        check("irq_pre", 64'(irq), 64'd0);
        @(posedge clk); #1;
        check("irq_rise", 64'(irq), 64'(m_irq()));
        rd(6'h08, "irq_pop");
        check("irq_fall", 64'(irq), 64'(m_irq()));

        // same-cycle CLR write and DATA read: read sees pre-clear head
        push_cycles(2, 32'h0, 1);
        m_read(6'h08, ed, er);
        fork
            axi_write(6'h00, 32'h0407, 4'h3, got_b);
            axi_read(6'h08, got_d, got_r, lat);
        join
        m_write(6'h00, 32'h0407, 4'h3, ew);
        check("clr_rd_data", 64'(got_d), 64'(ed));
        check("clr_rd_resp", 64'(got_r), 64'(er));
        check("clr_wr_resp", 64'(got_b), 64'(ew));
        rd(6'h04, "post_clr_status");

        // out-of-range addresses
        rd(6'h20, "bad_rd");
        wr(6'h2C, 32'hDEADBEEF, 4'hF, "bad_wr");
        rd(6'h0C, "bad_wr_ignored");

        // reset with a write response pending
        awaddr = 6'h10; wdata = 32'h12345678; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
        n = 0;
        while (!bvalid && n < BOUND) begin @(posedge clk); #1; n++; end
        awvalid = 0; wvalid = 0;
        check("bvalid_pending", 64'(bvalid), 64'd1);
        areset = 1;
        @(posedge clk); #1;
        check("rst_bvalid", 64'(bvalid), 64'd0);
        check("rst_rnd_rdy", 64'({irq, rnd_ready}), 64'd0);
        @(posedge clk); #1;
        areset = 0;
        m_reset();
        rd(6'h00, "post_rst_ctrl");
        rd(6'h04, "post_rst_status");
        for (int i = 3; i < 8; i++) rd(6'(i * 4), "post_rst_scr");
        wr(6'h10, 32'hCAFEF00D, 4'hF, "post_rst_w");
        rd(6'h10, "post_rst_r");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
